mmio_port_responder: RTL and testbench
======================================

# mmio_port_responder

Memory-mapped I/O responder on the processor's data-memory bus (MEM stage). It decodes a 16-byte address window and exposes four registers: a 32-bit output port register, an 8-bit input-port FIFO, a status register and a control register. The processor is the initiator; this block answers loads and stores alongside `DataMemory`, using the same address, write data and read/write strobes and returning read data in the same cycle. It replaces the constant `PortOut` tie-off and gives `PortIn` a buffered, strobe-captured path into software.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h1001_0000: window base, 16-byte aligned.
- `FIFO_DEPTH`, default 8: input FIFO entries, power of two, 2..256.

Ports:
- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  synchronous, active-low.
- `Address`  in  32  byte address from EX/MEM ALU result.
- `WriteData`  in  32  store data.
- `MemRead`  in  1  load strobe.
- `MemWrite`  in  1  store strobe.
- `ReadData`  out  32  load data, combinational.
- `Hit`  out  1  `Address` inside window; steers the processor's read-data mux.
- `PortIn`  in  8  external input byte, synchronous to `clk`.
- `PortInStrobe`  in  1  external push request; rising edge captures `PortIn`.
- `PortOut`  out  32  output port register.

## Operation
- Decode: `Hit = (Address[31:4] == BASE_ADDR[31:4])`. Register select is `Address[3:2]`, and `Address[1:0]` is ignored. Strobes have no effect when `Hit` is 0.
- Offset 0x0, PORT_OUT, read/write. A store loads all 32 bits. `PortOut` equals this register.
- Offset 0x4, PORT_IN, read-only.
  - A load returns `{24'b0, head}` and pops one entry at the clock edge.
  - A load on an empty FIFO returns 0, and nothing is popped.
  - Stores are ignored.
- Offset 0x8, STATUS, read-only. Stores are ignored.
  - bit0: empty.
  - bit1: full.
  - bit2: overflow (sticky).
  - bits[15:8]: count.
  - All other bits are 0.
- Offset 0xC, CONTROL.
  - Store bit0 = 1: clear overflow.
  - Store bit1 = 1: flush the FIFO (count, read pointer and write pointer go to 0). Flush does not clear overflow.
  - Store bit2: irq-enable (used only under `MMIO_IRQ_EN`).
  - Loads return `{29'b0, irq_en, 2'b0}`.
- Push: a rising edge of `PortInStrobe` (current 1, previous 0 in a strobe-history flop) writes `PortIn` at the tail.
  - When full, the byte is dropped and overflow is set.
  - A strobe held high pushes exactly once.
- `MemRead` and `MemWrite` asserted together: the store is performed, `ReadData` is still driven, and no pop occurs.
- Same-cycle cases:
  - Push + pop when full: both occur, count is unchanged, no overflow.
  - Push + pop when empty: the pop is ignored, the push is accepted, count becomes 1.
  - Flush + push: flush wins, the byte is discarded, no overflow.
  - Clear-overflow + overflowing push: overflow ends at 1 (set wins).
- Pointers are log2(`FIFO_DEPTH`) bits wide and wrap modulo `FIFO_DEPTH`. The count register is one bit wider.
- `ReadData` is 0 when `Hit` is 0 or `MemRead` is 0.

## Timing
- Reset, in the cycle after `reset` is sampled low:
  - `PortOut` = 0.
  - FIFO empty, count 0.
  - overflow = 0, irq_en = 0.
  - strobe-history flop = 0.
  - `irq` = 0.
  - FIFO storage contents are don't-care.
- Reset dominates every simultaneous store, pop or push. Reset mid-sequence discards all queued bytes.
- Read latency is zero: `ReadData` is valid in the same cycle as `MemRead`, so the processor's MEM/WB stage captures it at the next edge.
- Pop, push and register-update side effects take effect at the rising edge that ends the access cycle.
- A load in cycle N+1 observes the effects of a store or pop in cycle N.
- Push latency: with the strobe low in cycle N-1 and high in cycle N, the byte is visible at the FIFO head and in count from cycle N+1.
- There are no wait states and no stalls. Every access completes in one cycle.

## Configuration
- `MMIO_IRQ_EN` defined:
  - Adds output `irq` (1 bit, registered).
  - `irq` is 1 in the cycle after (irq_en & !empty) | (irq_en & overflow) becomes true, and drops one cycle after that condition goes false.
- `MMIO_IRQ_EN` undefined:
  - No `irq` port and no irq logic.
  - CONTROL bit2 is still stored and still readable, so software sees identical register behaviour.

## Test plan
- Reset then idle: `PortOut` = 0. Load 0x8 → 0x0000_0001. Load 0x4 → 0, and count stays 0.
- Store 0xDEAD_BEEF to BASE+0x0: `PortOut` = 0xDEAD_BEEF from the next cycle. Store to BASE+0x20 (outside the window): `Hit` = 0 and `PortOut` is unchanged.
- Push 0x11, 0x22, 0x33 via three strobe pulses (one strobe held high 5 cycles): STATUS = 0x0000_0300, then loads of 0x4 return 0x11, 0x22, 0x33 in order, and STATUS returns 0x0000_0001.
- Push 9 bytes with `FIFO_DEPTH` = 8: STATUS = 0x0000_0806. Store 0x1 to 0xC: STATUS = 0x0000_0802. Store 0x2 to 0xC: STATUS = 0x0000_0001.
- Full FIFO, with a push strobe edge and a load of 0x4 in the same cycle: the head byte is returned, count stays 8, overflow stays 0, and the new byte is last out after 8 pops (pointer wrap).
- Pull `reset` low while 5 bytes are queued and a store to 0x0 is in flight: next cycle `PortOut` = 0, STATUS = 0x0000_0001. Under `MMIO_IRQ_EN`, store 0x4 to 0xC then push one byte: `irq` = 1 one cycle after the push is visible, and 0 one cycle after the pop.

Source files
------------

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: memory-mapped I/O block on the data-memory bus.
// Decodes a 16-byte window at BASE_ADDR and exposes:
//   0x0 PORT_OUT (rw), 0x4 PORT_IN FIFO head (ro, load pops),
//   0x8 STATUS (ro), 0xC CONTROL (clear overflow / flush / irq enable).
// Optional feature macro: MMIO_IRQ_EN adds the registered `irq` output.
// Reads are combinational so a load completes in the same cycle as MemRead.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    input  logic        PortInStrobe,
    output logic [31:0] PortOut
`ifdef MMIO_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] SEL_PORT_OUT = 2'd0;
    localparam logic [1:0] SEL_PORT_IN  = 2'd1;
    localparam logic [1:0] SEL_STATUS   = 2'd2;
    localparam logic [1:0] SEL_CONTROL  = 2'd3;

    // Architectural state
    logic [31:0]      port_out_reg, port_out_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             irq_en_reg, irq_en_next;
    logic             strobe_hist_reg;
    logic [7:0]       fifo_mem [FIFO_DEPTH];

    // Decoded access qualifiers
    logic [1:0] sel;
    logic       rd_hit, wr_hit;
    logic       fifo_empty, fifo_full;
    logic       strobe_rise;
    logic       do_pop, do_push, set_overflow;
    logic       do_flush, do_clear_ovf;
    logic [7:0] head_byte;
    logic [7:0] count_byte;
    logic [31:0] status_word;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^Address[1:0];

    assign Hit    = (Address[31:4] == BASE_ADDR[31:4]);
    assign sel    = Address[3:2];
    assign rd_hit = Hit & MemRead;
    assign wr_hit = Hit & MemWrite;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));

    assign strobe_rise = PortInStrobe & ~strobe_hist_reg;

    // A combined read+write access performs the store but never pops.
    assign do_pop       = rd_hit & ~MemWrite & (sel == SEL_PORT_IN) & ~fifo_empty;
    assign do_flush     = wr_hit & (sel == SEL_CONTROL) & WriteData[1];
    assign do_clear_ovf = wr_hit & (sel == SEL_CONTROL) & WriteData[0];

    // A full FIFO still accepts a byte if a pop frees a slot in the same
    // cycle; flush discards the byte without flagging overflow.
    assign do_push      = strobe_rise & ~do_flush & (~fifo_full | do_pop);
    assign set_overflow = strobe_rise & ~do_flush & fifo_full & ~do_pop;

    assign head_byte = fifo_mem[rd_ptr_reg];

    // STATUS count field is 8 bits wide regardless of FIFO_DEPTH
    generate
        if (CNT_W <= 8) begin : g_count_narrow
            assign count_byte = 8'(count_reg);
        end else begin : g_count_wide
            assign count_byte = count_reg[7:0];
        end
    endgenerate

    assign status_word = {16'b0, count_byte, 5'b0, overflow_reg, fifo_full, fifo_empty};

    assign PortOut = port_out_reg;

    // Combinational load data, zero whenever the access is not a hit load
    always_comb begin
        ReadData = 32'b0;
        if (rd_hit) begin
            case (sel)
                SEL_PORT_OUT: ReadData = port_out_reg;
                SEL_PORT_IN:  ReadData = fifo_empty ? 32'b0 : {24'b0, head_byte};
                SEL_STATUS:   ReadData = status_word;
                default:      ReadData = {29'b0, irq_en_reg, 2'b0};
            endcase
        end
    end

    // Next-state computation for registers, pointers, count and flags
    always_comb begin
        port_out_next = port_out_reg;
        irq_en_next   = irq_en_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        count_next    = count_reg;

        if (wr_hit && sel == SEL_PORT_OUT) begin
            port_out_next = WriteData;
        end
        if (wr_hit && sel == SEL_CONTROL) begin
            irq_en_next = WriteData[2];
        end

        if (do_flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            end
            count_next = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end

        // Setting overflow takes priority over clearing it in the same cycle
        overflow_next = set_overflow | (overflow_reg & ~do_clear_ovf);
    end

    // Control/status state update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            port_out_reg    <= 32'b0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            overflow_reg    <= 1'b0;
            irq_en_reg      <= 1'b0;
            strobe_hist_reg <= 1'b0;
        end else begin
            port_out_reg    <= port_out_next;
            rd_ptr_reg      <= rd_ptr_next;
            wr_ptr_reg      <= wr_ptr_next;
            count_reg       <= count_next;
            overflow_reg    <= overflow_next;
            irq_en_reg      <= irq_en_next;
            strobe_hist_reg <= PortInStrobe;
        end
    end

    // FIFO storage write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            fifo_mem[wr_ptr_reg] <= PortIn;
        end
    end

`ifdef MMIO_IRQ_EN
    logic irq_reg;

    // Registered interrupt: pending data or overflow while enabled
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_en_reg & (~fifo_empty | overflow_reg);
        end
    end

    assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: directed steps from the
// test plan followed by randomized bus/strobe traffic, all compared against
// a queue-based behavioural model. Build with MMIO_IRQ_EN to check irq.
module tb_mmio_port_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic        Hit;
    logic [7:0]  PortIn;
    logic        PortInStrobe;
    logic [31:0] PortOut;
`ifdef MMIO_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    mmio_port_responder #(
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Address     (Address),
        .WriteData   (WriteData),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .ReadData    (ReadData),
        .Hit         (Hit),
        .PortIn      (PortIn),
        .PortInStrobe(PortInStrobe),
        .PortOut     (PortOut)
`ifdef MMIO_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0]  m_q[$];
    logic [31:0] m_port;
    bit          m_ovf;
    bit          m_irqen;
    bit          m_prev_stb;
    bit          m_irq;
    logic [31:0] last_rd;
    int          txn = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr, input bit rd);
        logic [31:0] r;
        logic [7:0]  cnt;
        r = 32'b0;
        if (rd && addr[31:4] == BASE[31:4]) begin
            case (addr[3:2])
                2'd0: r = m_port;
                2'd1: r = (m_q.size() > 0) ? {24'b0, m_q[0]} : 32'b0;
                2'd2: begin
                    cnt = 8'(m_q.size());
                    r = {16'b0, cnt, 5'b0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0)};
                end
                default: r = m_irqen ? 32'h4 : 32'h0;
            endcase
        end
        return r;
    endfunction

    // One bus cycle: drive, check outputs mid-cycle, advance model at the edge
    task automatic cycle(input bit rst_n, input logic [31:0] addr, input logic [31:0] wdata,
                         input bit rd, input bit wr, input logic [7:0] pin, input bit stb);
        bit hit, rise, flush, clr, pop, ovf_set, irq_nx;
        @(negedge clk);
        reset        = rst_n;
        Address      = addr;
        WriteData    = wdata;
        MemRead      = rd;
        MemWrite     = wr;
        PortIn       = pin;
        PortInStrobe = stb;
        #1;
        hit = (addr[31:4] == BASE[31:4]);
        check32("hit", {31'b0, Hit}, {31'b0, hit});
        check32("read_data", ReadData, model_read(addr, rd));
        check32("port_out", PortOut, m_port);
`ifdef MMIO_IRQ_EN
        check32("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
        last_rd = ReadData;
        $display("txn %0d: rst_n=%0d addr=%h wd=%h rd=%0d wr=%0d stb=%0d pin=%h -> rdata=%h hit=%0d out=%h q=%0d",
                 txn, rst_n, addr, wdata, rd, wr, stb, pin, ReadData, Hit, PortOut, m_q.size());
        txn++;

        irq_nx = m_irqen && (m_q.size() > 0 || m_ovf);
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_port     = 32'b0;
            m_ovf      = 0;
            m_irqen    = 0;
            m_prev_stb = 0;
            m_irq      = 0;
        end else begin
            rise  = stb && !m_prev_stb;
            m_prev_stb = stb;
            flush = 0;
            clr   = 0;
            if (hit && wr) begin
                if (addr[3:2] == 2'd0) m_port = wdata;
                if (addr[3:2] == 2'd3) begin
                    m_irqen = wdata[2];
                    clr     = wdata[0];
                    flush   = wdata[1];
                end
            end
            pop     = hit && rd && !wr && addr[3:2] == 2'd1 && m_q.size() > 0;
            ovf_set = 0;
            if (flush) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (rise) begin
                    if (m_q.size() < DEPTH) m_q.push_back(pin);
                    else ovf_set = 1;
                end
            end
            m_ovf = ovf_set || (m_ovf && !clr);
            m_irq = irq_nx;
        end
    endtask

    task automatic idle();
        cycle(1, 32'h0, 32'h0, 0, 0, 8'h00, 0);
    endtask

    task automatic load(input logic [3:0] off);
        cycle(1, BASE + 32'(off), 32'h0, 1, 0, 8'h00, 0);
    endtask

    task automatic store(input logic [3:0] off, input logic [31:0] d);
        cycle(1, BASE + 32'(off), d, 0, 1, 8'h00, 0);
    endtask

    task automatic push(input logic [7:0] b);
        cycle(1, 32'h0, 32'h0, 0, 0, b, 1);
        cycle(1, 32'h0, 32'h0, 0, 0, b, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        m_port = 32'b0; m_ovf = 0; m_irqen = 0; m_prev_stb = 0; m_irq = 0;
        reset = 1'b0; Address = 32'h0; WriteData = 32'h0; MemRead = 0; MemWrite = 0;
        PortIn = 8'h0; PortInStrobe = 0;

        // Reset then idle
        cycle(0, 32'h0, 32'h0, 0, 0, 8'h00, 0);
        cycle(0, 32'h0, 32'h0, 0, 0, 8'h00, 0);
        idle();
        check32("reset_port_out", PortOut, 32'h0);
        load(4'h8);
        check32("reset_status", last_rd, 32'h0000_0001);
        load(4'h4);
        check32("empty_pop", last_rd, 32'h0);
        load(4'h8);
        check32("empty_pop_count", last_rd, 32'h0000_0001);

        // PORT_OUT store and out-of-window store
        store(4'h0, 32'hDEAD_BEEF);
        idle();
        check32("port_out_store", PortOut, 32'hDEAD_BEEF);
        cycle(1, BASE + 32'h20, 32'h1234_5678, 0, 1, 8'h00, 0);
        check32("miss_hit", {31'b0, Hit}, 32'h0);
        idle();
        check32("miss_port_out", PortOut, 32'hDEAD_BEEF);

        // Three pushes, the last strobe held high for 5 cycles
        push(8'h11);
        push(8'h22);
        for (int i = 0; i < 5; i++) cycle(1, 32'h0, 32'h0, 0, 0, 8'h33, 1);
        idle();
        load(4'h8);
        check32("status_three", last_rd, 32'h0000_0300);
        load(4'h4); check32("pop_11", last_rd, 32'h11);
        load(4'h4); check32("pop_22", last_rd, 32'h22);
        load(4'h4); check32("pop_33", last_rd, 32'h33);
        load(4'h8);
        check32("status_drained", last_rd, 32'h0000_0001);

        // Overflow, clear overflow, flush
        for (int i = 0; i < 9; i++) push(8'(8'h40 + i));
        load(4'h8); check32("status_overflow", last_rd, 32'h0000_0806);
        store(4'hC, 32'h1);
        load(4'h8); check32("status_ovf_clr", last_rd, 32'h0000_0802);
        store(4'hC, 32'h2);
        load(4'h8); check32("status_flushed", last_rd, 32'h0000_0001);

        // Full FIFO with simultaneous push and pop, then drain across the wrap
        for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
        cycle(1, BASE + 32'h4, 32'h0, 1, 0, 8'hA5, 1);
        check32("full_push_pop_head", last_rd, 32'h50);
        cycle(1, BASE + 32'h8, 32'h0, 1, 0, 8'hA5, 0);
        check32("full_push_pop_status", last_rd, 32'h0000_0802);
        for (int i = 0; i < 8; i++) load(4'h4);
        check32("wrap_last_out", last_rd, 32'hA5);

        // Reset while bytes are queued and a PORT_OUT store is in flight
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
        cycle(0, BASE, 32'hFFFF_0000, 0, 1, 8'h00, 0);
        load(4'h8);
        check32("midreset_port_out", PortOut, 32'h0);
        check32("midreset_status", last_rd, 32'h0000_0001);

`ifdef MMIO_IRQ_EN
        store(4'hC, 32'h4);
        cycle(1, 32'h0, 32'h0, 0, 0, 8'h77, 1);  // edge: push
        cycle(1, 32'h0, 32'h0, 0, 0, 8'h77, 0);  // push visible
        check32("irq_before", {31'b0, irq}, 32'h0);
        idle();
        check32("irq_raised", {31'b0, irq}, 32'h1);
        load(4'h4);                               // pop
        idle();                                   // FIFO empty visible
        idle();
        check32("irq_dropped", {31'b0, irq}, 32'h0);
`endif

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 8) a = BASE + 32'({r[1:0], 2'(($urandom))});
            else if (r == 8) a = BASE + 32'h10 + 32'($urandom_range(0, 15));
            else a = $urandom;
            d = $urandom;
            // keep flushes rare so the FIFO gets to fill up
            if (a[31:4] == BASE[31:4] && a[3:2] == 2'd3 && ($urandom_range(0, 3) != 0))
                d[1] = 1'b0;
            cycle(($urandom_range(0, 199) != 0), a, d,
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                  8'($urandom), ($urandom_range(0, 1) == 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
